simd_shift_iter: RTL

- Multi-cycle, handshaked SIMD shift/rotate unit for the 64-bit datapath.
- Lane width is selectable per request (8/16/32/64 bits).
- Adds rotate-left and rotate-right in both directions, plus SLL and SRA.
- Applies one log-shifter stage per clock, so it sits behind the execute issue port where a registered, back-pressurable result is needed instead of a wide single-cycle barrel.

---
 rtl/simd_shift_iter_if.sv | 15 +
 rtl/simd_shift_iter.sv | 87 ++++++++
 2 files changed

// File: rtl/simd_shift_iter_if.sv
// simd_shift_iter_if: request/result handshake bundle for the iterative SIMD shifter.
// Vectors are plain MSB-first numbers; lane 0 is the most significant lane.
interface simd_shift_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [1:0]  ww;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;
    modport master(output in_valid, op, ww, ra, rb, out_ready, input in_ready, out_valid, out);
    modport slave(input in_valid, op, ww, ra, rb, out_ready, output in_ready, out_valid, out);
endinterface

// File: rtl/simd_shift_iter.sv
// simd_shift_iter: per-lane rotate/shift applying one log-shifter stage per clock.
module simd_shift_iter #(
    parameter int DW = 64
) (
    input logic             clk,
    input logic             reset,
    simd_shift_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [1:0]  r_ww;
    logic [2:0]  r_cnt;
    logic [DW-1:0] r_work;
    logic [DW-1:0] r_amt;
    logic [DW-1:0] r_out;
    logic        r_vld;
    logic [DW-1:0] w_next;
    logic        w_last;

    // Bit j lives in the lane whose LSB is at b; o is its offset inside that lane.
    function automatic logic [63:0] f_stage(input logic [63:0] v, input logic [63:0] a,
                                            input logic [1:0] op, input logic [1:0] ww,
                                            input logic [2:0] k);
        logic [63:0] r;
        int w, s, b, o;
        r = v;
        w = 8 << ww;
        s = 1 << k;
        for (int j = 0; j < 64; j++) begin
            b = j & ~(w - 1);
            o = j - b;
            r[j] = !a[b + int'(k)] ? v[j] :
                   op == 2'b00 ? v[b + ((o - s) & (w - 1))] :
                   op == 2'b01 ? v[b + ((o + s) & (w - 1))] :
                   op == 2'b10 ? (o + s < w ? v[j + s] : v[b + w - 1]) :
                   (o >= s ? v[j - s] : 1'b0);
        end
        return r;
    endfunction

    assign w_next = f_stage(r_work, r_amt, r_op, r_ww, r_cnt);
    assign w_last = r_cnt == {1'b0, r_ww} + 3'd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_ww    <= '0;
            r_cnt   <= '0;
            r_work  <= '0;
            r_amt   <= '0;
            r_out   <= '0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_op    <= bus.op;
                    r_ww    <= bus.ww;
                    r_work  <= bus.ra;
                    r_amt   <= bus.rb;
                    r_cnt   <= '0;
                    r_state <= BUSY;
                end
                BUSY: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 3'd1;
                    if (w_last) begin
                        r_out   <= w_next;
                        r_vld   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_vld   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_state == IDLE;
    assign bus.out_valid = r_vld;
    assign bus.out       = r_out;
endmodule
